// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, ALU controls,
// sequencer states and instruction field positions.
package cpu_pkg;

    // 4-bit opcode space; 0xB-0xE are unassigned and decode as NOP.
    typedef enum logic [3:0] {
        OP_AND  = 4'h0,
        OP_OR   = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_ANDI = 4'h4,
        OP_ORI  = 4'h5,
        OP_ADDI = 4'h6,
        OP_SUBI = 4'h7,
        OP_BEQ  = 4'h8,
        OP_BNE  = 4'h9,
        OP_JMP  = 4'hA,
        OP_HALT = 4'hF
    } op_e;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalted
    } seq_state_e;

    // Instruction field positions (rs2 overlaps the low nibble of imm).
    localparam int unsigned OP_HI  = 19;
    localparam int unsigned OP_LO  = 16;
    localparam int unsigned RD_HI  = 15;
    localparam int unsigned RD_LO  = 12;
    localparam int unsigned RS1_HI = 11;
    localparam int unsigned RS1_LO = 8;
    localparam int unsigned IMM_HI = 7;
    localparam int unsigned IMM_LO = 0;
    localparam int unsigned RS2_HI = 3;
    localparam int unsigned RS2_LO = 0;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational instruction decoder: register fields, immediate,
// ALU controls, raw write enable and control-flow flags.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [19:0] i_instr,
    output logic [3:0]  o_ra1,
    output logic [3:0]  o_ra2,
    output logic [3:0]  o_wa,
    output logic [7:0]  o_imm,
    output logic        o_alu_src,
    output logic [1:0]  o_alu_control,
    output logic        o_write_enable,
    output logic        o_is_branch,
    output logic        o_branch_on_zero,
    output logic        o_is_jump,
    output logic        o_is_halt
);

    logic [3:0] w_op;

    assign w_op  = i_instr[OP_HI:OP_LO];
    assign o_ra1 = i_instr[RS1_HI:RS1_LO];
    assign o_ra2 = i_instr[RS2_HI:RS2_LO];
    assign o_wa  = i_instr[RD_HI:RD_LO];
    assign o_imm = i_instr[IMM_HI:IMM_LO];

    // Opcode decode; anything unlisted behaves as a NOP.
    always_comb begin
        o_alu_src        = 1'b0;
        o_alu_control    = ALU_AND;
        o_write_enable   = 1'b0;
        o_is_branch      = 1'b0;
        o_branch_on_zero = 1'b0;
        o_is_jump        = 1'b0;
        o_is_halt        = 1'b0;
        case (w_op)
            OP_AND:  begin o_alu_control = ALU_AND; o_write_enable = 1'b1; end
            OP_OR:   begin o_alu_control = ALU_OR;  o_write_enable = 1'b1; end
            OP_ADD:  begin o_alu_control = ALU_ADD; o_write_enable = 1'b1; end
            OP_SUB:  begin o_alu_control = ALU_SUB; o_write_enable = 1'b1; end
            OP_ANDI: begin
                o_alu_control  = ALU_AND;
                o_alu_src      = 1'b1;
                o_write_enable = 1'b1;
            end
            OP_ORI: begin
                o_alu_control  = ALU_OR;
                o_alu_src      = 1'b1;
                o_write_enable = 1'b1;
            end
            OP_ADDI: begin
                o_alu_control  = ALU_ADD;
                o_alu_src      = 1'b1;
                o_write_enable = 1'b1;
            end
            OP_SUBI: begin
                o_alu_control  = ALU_SUB;
                o_alu_src      = 1'b1;
                o_write_enable = 1'b1;
            end
            OP_BEQ: begin
                // Compare by subtraction; datapath raises Zero on equality.
                o_alu_control    = ALU_SUB;
                o_is_branch      = 1'b1;
                o_branch_on_zero = 1'b1;
            end
            OP_BNE: begin
                o_alu_control = ALU_SUB;
                o_is_branch   = 1'b1;
            end
            OP_JMP:  o_is_jump = 1'b1;
            OP_HALT: o_is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/sequencing stage: program counter, run/halt FSM and a
// saturating retired-instruction counter around a combinational decoder.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [19:0]      instr,
    input  logic             Zero,
    output logic [PC_W-1:0]  instr_addr,
    output logic [3:0]       RA1,
    output logic [3:0]       RA2,
    output logic [3:0]       WA,
    output logic [7:0]       immediate,
    output logic             ALUSrc,
    output logic [1:0]       ALUControl,
    output logic             write_enable,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    seq_state_e       r_state;
    seq_state_e       w_state_next;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_next;
    logic [PC_W-1:0]  w_pc_inc;
    logic [PC_W-1:0]  w_target;
    logic [CNT_W-1:0] r_retired;
    logic [CNT_W-1:0] w_retired_next;

    logic       w_we_raw;
    logic       w_is_branch;
    logic       w_branch_on_zero;
    logic       w_is_jump;
    logic       w_is_halt;
    logic [7:0] w_imm;

    instr_decoder u_decoder (
        .i_instr          (instr),
        .o_ra1            (RA1),
        .o_ra2            (RA2),
        .o_wa             (WA),
        .o_imm            (w_imm),
        .o_alu_src        (ALUSrc),
        .o_alu_control    (ALUControl),
        .o_write_enable   (w_we_raw),
        .o_is_branch      (w_is_branch),
        .o_branch_on_zero (w_branch_on_zero),
        .o_is_jump        (w_is_jump),
        .o_is_halt        (w_is_halt)
    );

    assign immediate = w_imm;
    assign w_pc_inc  = r_pc + PC_W'(1);
    assign w_target  = PC_W'(w_imm);

    // Next-state logic for state, PC and retired counter.
    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_retired_next = r_retired;
        case (r_state)
            StIdle, StHalted: begin
                if (start) begin
                    w_state_next = StRun;
                    w_pc_next    = '0;
                end
            end
            StRun: begin
                if (start) begin
                    // Restart: the instruction in flight is dropped, not retired.
                    w_pc_next = '0;
                end else begin
                    if (r_retired != {CNT_W{1'b1}}) begin
                        w_retired_next = r_retired + CNT_W'(1);
                    end
                    if (w_is_halt) begin
                        w_state_next = StHalted;
                    end else if (w_is_jump) begin
                        w_pc_next = w_target;
                    end else if (w_is_branch && (Zero == w_branch_on_zero)) begin
                        w_pc_next = w_target;
                    end else begin
                        w_pc_next = w_pc_inc;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State, PC and counter registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_pc      <= '0;
            r_retired <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_retired <= w_retired_next;
        end
    end

    assign instr_addr   = r_pc;
    assign write_enable = w_we_raw && (r_state == StRun);
    assign running      = (r_state == StRun);
    assign halted       = (r_state == StHalted);
    assign retired      = r_retired;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

- Fetch/decode/sequencing stage directly upstream of the register-file/ALU datapath.
- Holds the 8-bit program counter and addresses an external combinational instruction ROM.
- Decodes each 20-bit instruction into register addresses, immediate, ALUSrc, ALUControl and write enable.
- Resolves branches in the same cycle from the datapath's Zero flag; a small run/halt FSM and a retired-instruction counter make it sequential.

## Interface
Parameters:
- PC_W, 8, program counter and ROM address width
- CNT_W, 16, retired-instruction counter width

Ports:
- clk  in  1  rising-edge clock; one clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; starts execution from PC 0
- instr  in  20  ROM data at instr_addr, combinational
- Zero  in  1  datapath ALU-result-is-zero flag, same cycle
- instr_addr  out  PC_W  current PC
- RA1, RA2, WA  out  4 each  register addresses
- immediate  out  8  immediate operand
- ALUSrc  out  1  1 = immediate as SrcB
- ALUControl  out  2  00 AND, 01 OR, 10 ADD, 11 SUB
- write_enable  out  1  register write strobe
- running  out  1  FSM in RUN
- halted  out  1  FSM in HALTED
- retired  out  CNT_W  instructions executed, saturating

## Operation
Instruction fields:
- op = instr[19:16]
- rd = instr[15:12]
- rs1 = instr[11:8]
- imm = instr[7:0]
- rs2 = instr[3:0]

Field mapping (all decode is combinational from instr):
- RA1 = rs1, RA2 = rs2, WA = rd, immediate = imm in every state.

Opcodes:
- 0x0–0x3 (AND/OR/ADD/SUB): ALUControl = op[1:0], ALUSrc = 0, write_enable = 1.
- 0x4–0x7 (ANDI/ORI/ADDI/SUBI): ALUControl = op[1:0], ALUSrc = 1, write_enable = 1.
- 0x8 BEQ: ALUControl = 11, ALUSrc = 0, write_enable = 0; next PC = imm if Zero, else PC+1.
- 0x9 BNE: as BEQ, with the condition inverted.
- 0xA JMP: write_enable = 0, ALUControl = 00, ALUSrc = 0; next PC = imm unconditionally.
- 0xF HALT: write_enable = 0; enter HALTED; PC holds.
- 0xB–0xE: NOP; write_enable = 0, ALUControl = 00, ALUSrc = 0; next PC = PC+1.

write_enable is forced to 0 in every state except RUN. WA = 0 is passed through unchanged; the datapath ignores writes to r0.

FSM states: IDLE, RUN, HALTED.
- IDLE → RUN on start; PC is loaded with 0.
- RUN → HALTED when a HALT instruction is decoded.
- HALTED → RUN on start; PC reloads 0. The retired counter is not cleared.
- start while in RUN restarts: PC = 0, and the current instruction is not retired.

PC arithmetic:
- PC+1 is modulo 2^PC_W; 0xFF wraps to 0x00.
- Branch/jump targets are imm truncated or zero-extended to PC_W.

retired counter:
- Increments by 1 on each RUN-state cycle that does not see start, HALT included.
- Saturates at all-ones.

## Timing
- Asynchronous reset (reset_n low): PC = 0, state = IDLE, retired = 0, running = 0, halted = 0.
- Output values during reset: write_enable = 0. All decode outputs follow instr combinationally, which is normally ROM[0].
- One instruction per cycle; zero pipeline latency.
- Decode outputs are valid combinationally within the cycle.
- PC, state and retired update on the rising edge of clk.
- Branch decision uses Zero from the same cycle. The combinational path is instr → RA1/RA2 → ALU → Zero → next PC; it is not a loop because Zero does not feed decode.
- running and halted are registered state decodes, valid the cycle after each transition.
- Reset asserted mid-program returns to IDLE immediately. The register file is not affected.

## Structure
Shared package `cpu_pkg`:
- opcode enum op_e (OP_AND…OP_SUBI, OP_BEQ, OP_BNE, OP_JMP, OP_HALT)
- ALUControl localparams
- state enum seq_state_e
- field-position constants

Sub-module `instr_decoder`: purely combinational, maps instr to the control outputs plus is_branch/is_jump/is_halt. The sequencer top holds the PC, FSM and counter and instantiates the decoder.

## Test plan
- Reset then start, ROM = {ADDI r1,r0,5; ADDI r2,r0,5; HALT}:
  - instr_addr steps 0, 1, 2.
  - write_enable = 1 for the two ADDIs with WA = 1, 2, ALUSrc = 1, ALUControl = 10.
  - halted = 1 afterwards; retired = 3.
- BEQ r1,r2,0x10 with Zero = 1 → next instr_addr = 0x10. The same instruction with Zero = 0 → next instr_addr = PC+1. write_enable = 0 and ALUControl = 11 in both cases.
- BNE with Zero = 0 → branch taken. JMP 0xFF followed by an ADD at 0xFF → PC wraps to 0x00.
- Opcode 0xC → NOP: write_enable = 0, PC increments, retired increments.
- start pulsed while in RUN at PC = 7 → PC = 0 next cycle; retired does not count that cycle.
- reset_n pulsed low mid-cycle while in RUN → outputs reset immediately, asynchronously: state IDLE, write_enable = 0, PC = 0, retired = 0.
